// File: rtl/nibble_lane_distributor.sv
// Scatters 4-bit nibbles from one upstream port into six single-entry lane registers.
// Supports per-lane or broadcast delivery, a highest-occupied-lane report and a saturating drop counter.
module nibble_lane_distributor #(
    parameter int DATA_W = 4,
    parameter int LANES  = 6,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_sel,
    input  logic [DATA_W-1:0]         in_data,
    output logic [LANES-1:0]          lane_valid,
    input  logic [LANES-1:0]          lane_ready,
    output logic [LANES*DATA_W-1:0]   lane_data,
    output logic [2:0]                hp_lane,
    output logic                      any_valid,
    output logic [CNT_W-1:0]          drop_cnt
);

    logic [LANES-1:0]  valid_q;
    logic [LANES-1:0]  valid_d;
    logic [DATA_W-1:0] data_q [LANES];
    logic [DATA_W-1:0] data_d [LANES];
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;

    logic [LANES-1:0]  lane_free;
    logic [LANES-1:0]  sel_hit;
    logic [LANES-1:0]  lane_load;
    logic              drop_class;
    logic              bcast;
    logic              xfer;

    // A null nibble is dropped whatever the select says, so it is checked first.
    assign drop_class = (in_data == '0) || (in_sel == 3'd6);
    assign bcast      = (in_sel == 3'd7);
    assign lane_free  = ~valid_q | lane_ready;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (drop_class) begin
                in_ready = 1'b1;
            end else if (bcast) begin
                in_ready = &lane_free;
            end else begin
                in_ready = |(sel_hit & lane_free);
            end
        end
    end

    assign xfer = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign sel_hit[gi]   = (in_sel == 3'(gi));
            assign lane_load[gi] = xfer & ~drop_class & (bcast | sel_hit[gi]);

            // A load on the same edge as a pop keeps the lane occupied with the new nibble.
            always_comb begin
                valid_d[gi] = valid_q[gi] & ~lane_ready[gi];
                data_d[gi]  = data_q[gi];
                if (lane_load[gi]) begin
                    valid_d[gi] = 1'b1;
                    data_d[gi]  = in_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q[gi] <= 1'b0;
                    data_q[gi]  <= '0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    data_q[gi]  <= data_d[gi];
                end
            end

            assign lane_data[gi*DATA_W +: DATA_W] = data_q[gi];
        end
    endgenerate

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (xfer && drop_class && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Ascending scan so the highest occupied index wins.
    always_comb begin
        hp_lane = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            if (valid_q[i]) begin
                hp_lane = 3'(i);
            end
        end
    end

    assign any_valid  = |valid_q;
    assign lane_valid = valid_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_nibble_lane_distributor.sv
// Directed and random bench for nibble_lane_distributor.
// A behavioural model queues each expected post-edge state; it is popped and compared after the edge.
module tb_nibble_lane_distributor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [3:0]  in_data;
    logic [5:0]  lane_valid;
    logic [5:0]  lane_ready;
    logic [23:0] lane_data;
    logic [2:0]  hp_lane;
    logic        any_valid;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [5:0]  v;
        logic [23:0] d;
        logic [2:0]  hp;
        logic        a;
        logic [7:0]  c;
    } exp_t;

    exp_t exp_q[$];

    logic [5:0]  mdl_valid;
    logic [23:0] mdl_data;
    logic [7:0]  mdl_cnt;

    int vectors;
    int miscompares;

    nibble_lane_distributor #(.DATA_W(4), .LANES(6), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_data  (lane_data),
        .hp_lane    (hp_lane),
        .any_valid  (any_valid),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] mdl_hp(input logic [5:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
                break;
            end
        end
        return r;
    endfunction

    task automatic mdl_reset();
        mdl_valid = '0;
        mdl_data  = '0;
        mdl_cnt   = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, check in_ready before the edge, check the queued state after it.
    task automatic step(input logic v, input logic [2:0] sel, input logic [3:0] d,
                        input logic [5:0] rdy, input string tag);
        logic [5:0] free;
        logic       drop;
        logic       er;
        logic       xfer;
        exp_t       e;
        exp_t       got;
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        lane_ready = rdy;
        #1;
        free = ~mdl_valid | rdy;
        drop = (d == 4'h0) || (sel == 3'd6);
        if (drop)             er = 1'b1;
        else if (sel == 3'd7) er = &free;
        else                  er = free[sel];
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        xfer = v & er;
        for (int i = 0; i < 6; i++) begin
            if (mdl_valid[i] && rdy[i]) mdl_valid[i] = 1'b0;
            if (xfer && !drop && (sel == 3'd7 || sel == 3'(i))) begin
                mdl_valid[i]       = 1'b1;
                mdl_data[i*4 +: 4] = d;
            end
        end
        if (xfer && drop && mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
        e.v  = mdl_valid;
        e.d  = mdl_data;
        e.hp = mdl_hp(mdl_valid);
        e.a  = |mdl_valid;
        e.c  = mdl_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, ".lane_valid"}, 32'(lane_valid), 32'(got.v));
        chk({tag, ".lane_data"},  32'(lane_data),  32'(got.d));
        chk({tag, ".hp_lane"},    32'(hp_lane),    32'(got.hp));
        chk({tag, ".any_valid"},  32'(any_valid),  32'(got.a));
        chk({tag, ".drop_cnt"},   32'(drop_cnt),   32'(got.c));
        $display("step %-10s v=%0b sel=%0d d=%h rdy=%b -> ready=%0b lane_valid=%b lane_data=%h hp=%0d cnt=%0d",
                 tag, v, sel, d, rdy, er, lane_valid, lane_data, hp_lane, drop_cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".lane_valid"}, 32'(lane_valid), 32'h0);
        chk({tag, ".lane_data"},  32'(lane_data),  32'h0);
        chk({tag, ".hp_lane"},    32'(hp_lane),    32'h0);
        chk({tag, ".any_valid"},  32'(any_valid),  32'h0);
        chk({tag, ".drop_cnt"},   32'(drop_cnt),   32'h0);
        chk({tag, ".in_ready"},   32'(in_ready),   32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_sel      = 3'd7;
        in_data     = 4'hF;
        lane_ready  = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 3'd2, 4'hA, 6'b000000, "load2");
        chk("load2.exact_valid", 32'(lane_valid), 32'h04);
        chk("load2.exact_data2", 32'(lane_data[11:8]), 32'hA);
        chk("load2.exact_hp",    32'(hp_lane), 32'd2);

        step(1'b1, 3'd2, 4'h5, 6'b000000, "full2");
        chk("full2.keeps_A", 32'(lane_data[11:8]), 32'hA);
        step(1'b1, 3'd2, 4'h5, 6'b000100, "popload2");
        chk("popload2.data5", 32'(lane_data[11:8]), 32'h5);
        chk("popload2.valid", 32'(lane_valid[2]), 32'h1);

        step(1'b1, 3'd4, 4'h7, 6'b000000, "load4");
        step(1'b0, 3'd0, 4'h0, 6'b000100, "pop2");
        step(1'b1, 3'd7, 4'hF, 6'b000000, "bc_block");
        step(1'b1, 3'd7, 4'hF, 6'b010000, "bc_go");
        chk("bc_go.valid3F", 32'(lane_valid), 32'h3F);
        chk("bc_go.dataF",   32'(lane_data),  32'hFFFFFF);
        chk("bc_go.hp5",     32'(hp_lane),    32'd5);

        step(1'b1, 3'd6, 4'h3, 6'b000000, "drop_sel6");
        step(1'b1, 3'd1, 4'h0, 6'b000000, "drop_null");
        chk("drops.cnt2", 32'(drop_cnt), 32'd2);
        chk("drops.valid", 32'(lane_valid), 32'h3F);

        step(1'b1, 3'd7, 4'h0, 6'b000000, "drop_bc0");
        step(1'b0, 3'd0, 4'h0, 6'b111111, "popall");
        step(1'b0, 3'd0, 4'h0, 6'b111111, "idle_rdy");

        for (int n = 0; n < 40; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 6'($urandom_range(0, 63)), "rand");
        end

        for (int n = 0; n < 300; n++) begin
            step(1'b1, (n % 2 == 0) ? 3'd6 : 3'd3, (n % 2 == 0) ? 4'h9 : 4'h0,
                 6'($urandom_range(0, 63)), "sat");
        end
        chk("sat.cnt255", 32'(drop_cnt), 32'd255);

        step(1'b0, 3'd0, 4'h0, 6'b111111, "drain");
        step(1'b1, 3'd0, 4'h8, 6'b000000, "fill0");
        step(1'b1, 3'd3, 4'h9, 6'b000000, "fill3");
        step(1'b1, 3'd5, 4'hC, 6'b000000, "fill5");
        chk("fill.valid29", 32'(lane_valid), 32'h29);

        in_valid   = 1'b1;
        in_sel     = 3'd7;
        in_data    = 4'hF;
        lane_ready = '0;
        rst_n      = 1'b0;
        #1;
        chk_all_zero("midrst");
        mdl_reset();
        @(posedge clk);
        #1;
        chk_all_zero("midrst_edge");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 4'h1;
        #1;
        chk("post_rst.pre_edge_valid", 32'(lane_valid), 32'h0);
        step(1'b1, 3'd0, 4'h1, 6'b000000, "post_rst");
        chk("post_rst.valid1", 32'(lane_valid), 32'h01);
        chk("post_rst.data1",  32'(lane_data),  32'h000001);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
